// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter. The FIFO applies back-pressure through
// O_TX_FULL. Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_fifo #(
    parameter int ADDR_W       = 4,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              I_WR_UART,
    input  logic [7:0]        I_DATA_UART,
    input  logic              I_CLR_OVF,
    output logic              O_TX_FULL,
    output logic              O_TX_EMPTY,
    output logic [ADDR_W:0]   O_COUNT,
    output logic              O_OVERFLOW,
    output logic              O_TX,
    output logic              O_TX_BUSY,
    output logic              O_TX_DONE
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [ADDR_W:0]  FULL_CNT  = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // ---------------- FIFO ----------------
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              full, empty, push, drop, pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign push  = I_WR_UART && !full;
    assign drop  = I_WR_UART && full;

    // NOTE: the storage array has no reset; occupancy and pointers alone define validity.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= I_DATA_UART;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A dropped write wins over a same-cycle clear so the loss is never hidden.
            if (drop)           overflow <= 1'b1;
            else if (I_CLR_OVF) overflow <= 1'b0;
        end
    end

    // ---------------- Transmitter ----------------
    state_t           state, state_d;
    logic [CNT_W-1:0] baud, baud_d;
    logic [2:0]       bit_idx, bit_d;
    logic [7:0]       shift, shift_d;
    logic             tx_q, tx_d;
    logic             baud_last;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    assign baud_last = (baud == BAUD_LAST);

    // NOTE: sequential state uses non-blocking assignments; the combinational block below uses blocking ones.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            baud    <= baud_d;
            bit_idx <= bit_d;
            shift   <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // The line register is loaded with the value of the coming cycle, so O_TX tracks state with no extra lag.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        state_d = state;
        baud_d  = baud;
        bit_d   = bit_idx;
        shift_d = shift;
        tx_d    = tx_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                    par_d   = ^mem[rd_ptr];
`endif
                    baud_d  = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = shift[0];
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift >> 1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_idx + 3'd1;
                        tx_d  = shift[1];
                    end
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign O_TX       = tx_q;
    assign O_TX_BUSY  = (state != IDLE);
    assign O_TX_DONE  = (state == STOP) && baud_last;
    assign O_TX_FULL  = full;
    assign O_TX_EMPTY = empty;
    assign O_COUNT    = count;
    assign O_OVERFLOW = overflow;

endmodule
